// File: rtl/matrix_line_buffer_pkg.sv
// Shared constants and fill-state type for the canny line-buffer stage.
// Holds the image geometry defaults and the pixel range limits.
package matrix_line_buffer_pkg;

    localparam logic [10:0] DEF_PIC_WIDTH = 11'd250;
    localparam int          DEF_WIDTH     = 8;
    // One bit of headroom above the minimum column width, so 250 columns use a 9-bit counter.
    localparam int          DEF_ADDR_W    = $clog2(DEF_PIC_WIDTH) + 1;

    localparam logic [7:0]  PIX_MAX = 8'd255;
    localparam logic [7:0]  PIX_MIN = 8'd0;

    // Number of complete rows held in the line RAMs, saturating once the window is full.
    typedef enum logic [1:0] {
        FILL_ROW0 = 2'd0,
        FILL_ROW1 = 2'd1,
        STREAM    = 2'd2
    } fill_state_e;

    function automatic fill_state_e advance_row(input fill_state_e s);
        fill_state_e r;
        case (s)
            FILL_ROW0: r = FILL_ROW1;
            FILL_ROW1: r = STREAM;
            default:   r = STREAM;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/matrix_line_buffer_line_ram.sv
// Single-row delay memory: one write port and an asynchronous read at the same
// address, so the read returns the value stored before this cycle's write.
module line_ram #(
    parameter int DEPTH = 250,
    parameter int WIDTH = 8,
    parameter int AW    = 9
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    // Array spans the whole address space so every address width maps cleanly;
    // only the first DEPTH entries are ever addressed.
    localparam int SLOTS = (DEPTH > (1 << AW)) ? DEPTH : (1 << AW);

    logic [WIDTH-1:0] r_mem [SLOTS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/matrix_line_buffer.sv
// Turns one raster pixel stream into three column-aligned streams from rows
// n-2, n-1 and n, feeding the 3x3 window stages of the canny pipeline.
module matrix_line_buffer
    import matrix_line_buffer_pkg::*;
#(
    parameter logic [10:0] PIC_WIDTH = DEF_PIC_WIDTH,
    parameter int          WIDTH     = DEF_WIDTH,
    parameter int          ADDR_W    = DEF_ADDR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [WIDTH-1:0] dout3,
    output logic             valid_out
);

    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(PIC_WIDTH - 11'd1);

    logic [ADDR_W-1:0] r_col;
    logic [ADDR_W-1:0] w_col_eff;
    logic [ADDR_W-1:0] w_col_next;
    fill_state_e       r_state;
    fill_state_e       w_state_eff;
    fill_state_e       w_state_next;
    logic              w_last;
    logic              w_window_ready;

    logic [WIDTH-1:0]  w_rd_a;
    logic [WIDTH-1:0]  w_rd_b;
    logic [WIDTH-1:0]  r_dout1;
    logic [WIDTH-1:0]  r_dout2;
    logic [WIDTH-1:0]  r_dout3;
    logic              r_valid_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL_ROW0;
            r_col   <= '0;
        end else begin
            r_state <= w_state_next;
            r_col   <= w_col_next;
        end
    end

    // frame_start overrides the tracked position for this very cycle, so a
    // coincident pixel lands at column 0 of row 0.
    always_comb begin
        w_col_eff    = frame_start ? '0 : r_col;
        w_state_eff  = frame_start ? FILL_ROW0 : r_state;
        w_last       = (w_col_eff == LAST_COL);
        w_col_next   = w_col_eff;
        w_state_next = w_state_eff;
        if (valid_in) begin
            if (w_last) begin
                w_col_next   = '0;
                w_state_next = advance_row(w_state_eff);
            end else begin
                w_col_next   = w_col_eff + ADDR_W'(1);
            end
        end
    end

    always_comb begin
        w_window_ready = (w_state_eff == STREAM);
    end

    // ram_a holds the previous row; its old word shifts down into ram_b.
    line_ram #(
        .DEPTH (int'(PIC_WIDTH)),
        .WIDTH (WIDTH),
        .AW    (ADDR_W)
    ) u_ram_a (
        .clk     (clk),
        .i_we    (valid_in),
        .i_addr  (w_col_eff),
        .i_wdata (din),
        .o_rdata (w_rd_a)
    );

    line_ram #(
        .DEPTH (int'(PIC_WIDTH)),
        .WIDTH (WIDTH),
        .AW    (ADDR_W)
    ) u_ram_b (
        .clk     (clk),
        .i_we    (valid_in),
        .i_addr  (w_col_eff),
        .i_wdata (w_rd_a),
        .o_rdata (w_rd_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout1     <= '0;
            r_dout2     <= '0;
            r_dout3     <= '0;
            r_valid_out <= 1'b0;
        end else begin
            r_valid_out <= valid_in && w_window_ready;
            if (valid_in) begin
                r_dout3 <= din;
                r_dout2 <= w_rd_a;
                r_dout1 <= w_rd_b;
            end
        end
    end

    assign dout1     = r_dout1;
    assign dout2     = r_dout2;
    assign dout3     = r_dout3;
    assign valid_out = r_valid_out;

endmodule

// File: tb/tb_matrix_line_buffer.sv
// Directed bench: a 4-pixel-wide instance for window alignment checks and a
// 250-pixel-wide instance for the long run, both driven from the same stream.
module tb_matrix_line_buffer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       valid_in = 1'b0;
    logic [7:0] din = 8'd0;

    logic [7:0] s_dout1, s_dout2, s_dout3;
    logic       s_valid;
    logic [7:0] b_dout1, b_dout2, b_dout3;
    logic       b_valid;

    int n_assert = 0;
    int n_fail   = 0;
    int n_bvalid = 0;

    always #5 clk = ~clk;

    matrix_line_buffer #(.PIC_WIDTH(11'd4), .WIDTH(8), .ADDR_W(9)) u_small (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .valid_in    (valid_in),
        .din         (din),
        .dout1       (s_dout1),
        .dout2       (s_dout2),
        .dout3       (s_dout3),
        .valid_out   (s_valid)
    );

    matrix_line_buffer #(.PIC_WIDTH(11'd250), .WIDTH(8), .ADDR_W(9)) u_big (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .valid_in    (valid_in),
        .din         (din),
        .dout1       (b_dout1),
        .dout2       (b_dout2),
        .dout3       (b_dout3),
        .valid_out   (b_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_small(input string tag, input logic v,
                             input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3);
        chk({tag, " valid"}, 32'(s_valid), 32'(v));
        chk({tag, " dout1"}, 32'(s_dout1), 32'(e1));
        chk({tag, " dout2"}, 32'(s_dout2), 32'(e2));
        chk({tag, " dout3"}, 32'(s_dout3), 32'(e3));
    endtask

    // Apply inputs for one cycle, then settle just after the rising edge.
    task automatic step(input logic fs, input logic v, input logic [7:0] d);
        frame_start = fs;
        valid_in    = v;
        din         = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pix(input int i);
        return 8'((i * 7 + 3) % 256);
    endfunction

    initial begin
        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        chk_small("reset", 1'b0, 8'd0, 8'd0, 8'd0);
        chk("reset big valid", 32'(b_valid), 32'd0);
        chk("reset big dout3", 32'(b_dout3), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 8'd0);
            chk_small("idle", 1'b0, 8'd0, 8'd0, 8'd0);
            chk("idle big valid", 32'(b_valid), 32'd0);
        end
        $display("phase reset/idle done");

        // Basic fill of three 4-pixel rows
        step(1'b1, 1'b0, 8'd0);
        chk("fill fs valid", 32'(s_valid), 32'd0);
        for (int p = 1; p <= 12; p++) begin
            step(1'b0, 1'b1, 8'(p));
            if (p <= 8) begin
                chk("fill early valid", 32'(s_valid), 32'd0);
                chk("fill early dout3", 32'(s_dout3), 32'(p));
            end else begin
                chk_small("fill window", 1'b1, 8'(p - 8), 8'(p - 4), 8'(p));
            end
        end
        step(1'b0, 1'b0, 8'd0);
        chk_small("fill hold", 1'b0, 8'd4, 8'd8, 8'd12);
        $display("phase basic fill done");

        // Stall between pixels 10 and 11
        step(1'b1, 1'b0, 8'd0);
        for (int p = 1; p <= 10; p++) begin
            step(1'b0, 1'b1, 8'(p));
            if (p <= 8) chk("stall early valid", 32'(s_valid), 32'd0);
            else        chk_small("stall window", 1'b1, 8'(p - 8), 8'(p - 4), 8'(p));
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 8'd77);
            chk_small("stall gap", 1'b0, 8'd2, 8'd6, 8'd10);
        end
        for (int p = 11; p <= 12; p++) begin
            step(1'b0, 1'b1, 8'(p));
            chk_small("stall resume", 1'b1, 8'(p - 8), 8'(p - 4), 8'(p));
        end
        $display("phase stall done");

        // frame_start coinciding with the first pixel of a new frame
        step(1'b1, 1'b1, 8'd100);
        chk("fs+pix valid", 32'(s_valid), 32'd0);
        chk("fs+pix dout3", 32'(s_dout3), 32'd100);
        for (int p = 101; p <= 111; p++) begin
            step(1'b0, 1'b1, 8'(p));
            if (p < 108) chk("fs+pix early valid", 32'(s_valid), 32'd0);
            else         chk_small("fs+pix window", 1'b1, 8'(p - 8), 8'(p - 4), 8'(p));
        end
        $display("phase frame_start with pixel done");

        // Asynchronous reset during row 2
        step(1'b1, 1'b0, 8'd0);
        for (int p = 1; p <= 9; p++) step(1'b0, 1'b1, 8'(p));
        chk_small("pre-rst window", 1'b1, 8'd1, 8'd5, 8'd9);
        valid_in = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_small("async rst now", 1'b0, 8'd0, 8'd0, 8'd0);
        @(posedge clk);
        #1;
        chk_small("async rst held", 1'b0, 8'd0, 8'd0, 8'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int p = 20; p <= 31; p++) begin
            step(1'b0, 1'b1, 8'(p));
            if (p < 28) chk("post-rst early valid", 32'(s_valid), 32'd0);
            else        chk_small("post-rst window", 1'b1, 8'(p - 8), 8'(p - 4), 8'(p));
        end
        $display("phase async reset done");

        // Five rows through the 250-wide instance
        step(1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 1250; i++) begin
            step(1'b0, 1'b1, pix(i));
            chk("long valid", 32'(b_valid), (i >= 500) ? 32'd1 : 32'd0);
            chk("long dout3", 32'(b_dout3), 32'(pix(i)));
            if (i >= 250) chk("long dout2", 32'(b_dout2), 32'(pix(i - 250)));
            if (i >= 500) chk("long dout1", 32'(b_dout1), 32'(pix(i - 500)));
            if (b_valid === 1'b1) n_bvalid++;
        end
        chk("long valid count", 32'(n_bvalid), 32'd750);
        step(1'b0, 1'b0, 8'd0);
        chk("long tail valid", 32'(b_valid), 32'd0);
        $display("phase long run done, %0d valid cycles", n_bvalid);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
